multiplexador_arbitrado: RTL and testbench
==========================================

Name: multiplexador_arbitrado

Overview:
- Parametrised, registered successor to the datapath 4:1 bus multiplexer.
- Selects one of CHANNELS source words onto a single output register, using valid/ready handshakes on every source and on the sink.
- Two selection modes: fixed index, as the existing mux does, or round-robin arbitration.
- Sits between register-file/ALU/immediate sources and the shared processor bus, so several producers can contend for the bus without data loss.

Parameters:
- WIDTH, 16, bit width of each data word.
- CHANNELS, 4, number of source channels (2..16).
- SELW, 2, select/grant index width; must satisfy 2**SELW >= CHANNELS.

Ports:
- p_Clock  input  1  rising-edge clock.
- p_Resetn  input  1  synchronous reset, active low; sampled on the p_Clock rising edge.
- p_Data  input  CHANNELS*WIDTH  flattened source words; channel i occupies bits [i*WIDTH +: WIDTH].
- p_Valid  input  CHANNELS  per-channel request; channel i's word is offered.
- p_Ready  output  CHANNELS  per-channel accept; combinational, at most one bit high.
- p_Mode  input  1  0 = fixed select, 1 = round-robin.
- p_Control  input  SELW  channel index used when p_Mode = 0.
- p_Output  output  WIDTH  registered bus word.
- p_Out_Valid  output  1  p_Output holds an undelivered word.
- p_Out_Ready  input  1  sink accepts p_Output this cycle.
- p_Grant  output  SELW  index of the channel that produced the current p_Output.

Behaviour:
- Clocking and reset:
  - Single clock domain, p_Clock.
  - Reset is synchronous and active-low on p_Resetn; all state changes occur on the rising edge.
  - While p_Resetn = 0 at an edge: p_Output = 0, p_Out_Valid = 0, p_Grant = 0, round-robin pointer last = CHANNELS-1 (so channel 0 has first priority).
  - p_Ready is all zeros during any cycle in which p_Resetn = 0.
  - A held word is discarded by reset, even mid-transfer.
- Storage: one output register plus a full flag (full drives p_Out_Valid). Two states:
  - EMPTY: full = 0.
  - FULL: full = 1; p_Output and p_Grant are stable until the transfer completes.
- Candidate channel c, computed combinationally each cycle:
  - Mode 0: c = p_Control if p_Control < CHANNELS and p_Valid[p_Control] = 1; otherwise no candidate. Other channels' valids are ignored.
  - Mode 1: c = first i with p_Valid[i] = 1, scanning last+1, last+2, ... modulo CHANNELS. No candidate if p_Valid = 0.
- Load condition: load = candidate exists AND (full = 0 OR p_Out_Ready = 1).
  - p_Ready[c] = load; all other p_Ready bits are 0.
  - A source transfer occurs when p_Valid[c] and p_Ready[c] are both 1.
- On a load edge:
  - p_Output <= p_Data[c]
  - p_Grant <= c
  - full <= 1
  - last <= c (last updates in both modes)
- Drain without refill: on an edge where full = 1, p_Out_Ready = 1 and load = 0, full <= 0. p_Output and p_Grant keep their old values.
- Simultaneous drain and load: the old word is delivered and the new word is captured on the same edge, giving back-to-back throughput of one word per cycle.
- Sink stall: when full = 1 and p_Out_Ready = 0, all p_Ready bits are 0 and the output is held indefinitely.
- Latency: one cycle, from the source transfer edge to p_Out_Valid/p_Output visible.
- Mode and selection changes:
  - A change to p_Mode or p_Control affects only the next selection; a held word is never altered.
  - Sources may drop p_Valid before they are granted; no state is affected.
- Fairness: in mode 1, with all channels continuously valid and the sink always ready, grants cycle 0, 1, ..., CHANNELS-1, 0, ...
- The block never reorders or duplicates words from a given channel.

Test Plan:
1. Reset, then mode 0, p_Control = 2, p_Valid = 4'b0100, channel 2 word = 16'hBEEF, p_Out_Ready = 1 → p_Ready = 4'b0100 in the same cycle; next cycle p_Output = 16'hBEEF, p_Out_Valid = 1, p_Grant = 2.
2. Mode 0, p_Control = 1, p_Valid = 4'b1101 → p_Ready = 0 and p_Out_Valid stays 0.
3. Mode 1, p_Valid = 4'b1111 held, p_Out_Ready = 1, for 8 cycles → p_Grant sequence 0,1,2,3,0,1,2,3 with one word per cycle and no bubbles.
4. p_Out_Valid = 1 with p_Output = 16'h1234, p_Out_Ready = 0 for 5 cycles while channel 3 stays valid → p_Output remains 16'h1234 and p_Ready = 0 throughout. Raise p_Out_Ready → channel 3's word is loaded on that same edge.
5. Mode 1, last = 1, p_Valid = 4'b0011 → grant goes to channel 0 (wrap past 2 and 3), not channel 1.
6. Pull p_Resetn low while p_Out_Valid = 1 → after the edge p_Out_Valid = 0, p_Output = 0, p_Grant = 0. With p_Resetn low and p_Valid = 4'b1111, p_Ready = 0. The first round-robin grant after release is channel 0.

Source files
------------

// File: rtl/multiplexador_arbitrado.sv
// multiplexador_arbitrado: registered CHANNELS:1 bus multiplexer with
// valid/ready handshakes on every source and on the sink. The source word is
// picked either by a fixed index (p_Control) or by round-robin arbitration,
// and held in a single output register until the sink takes it.
module multiplexador_arbitrado #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      p_Clock,
  input  logic                      p_Resetn,
  input  logic [CHANNELS*WIDTH-1:0] p_Data,
  input  logic [CHANNELS-1:0]       p_Valid,
  output logic [CHANNELS-1:0]       p_Ready,
  input  logic                      p_Mode,
  input  logic [SELW-1:0]           p_Control,
  output logic [WIDTH-1:0]          p_Output,
  output logic                      p_Out_Valid,
  input  logic                      p_Out_Ready,
  output logic [SELW-1:0]           p_Grant
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            stateQ, stateD;
  logic [WIDTH-1:0]  outQ, outD;
  logic [SELW-1:0]   grantQ, grantD;
  logic [SELW-1:0]   lastQ, lastD;

  logic              candValid;
  logic [SELW-1:0]   candIdx;
  logic [WIDTH-1:0]  candData;
  logic              load;

  // Pick this cycle's candidate channel: fixed index in mode 0, otherwise
  // the first valid channel scanning upward from the one after the last grant.
  always_comb begin
    int idx;
    candValid = 1'b0;
    candIdx   = '0;
    idx       = 0;
    if (!p_Mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (p_Control == SELW'(i) && p_Valid[i]) begin
          candValid = 1'b1;
          candIdx   = SELW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        idx = (int'(lastQ) + k) % CHANNELS;
        if (!candValid && p_Valid[idx]) begin
          candValid = 1'b1;
          candIdx   = SELW'(idx);
        end
      end
    end
  end

  // Route the candidate's word towards the output register.
  always_comb begin
    candData = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (candIdx == SELW'(i)) begin
        candData = p_Data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A new word can enter when the register is empty or is being drained on
  // this same edge; nothing is accepted while reset is asserted.
  always_comb begin
    load    = p_Resetn && candValid && ((stateQ == EMPTY) || p_Out_Ready);
    p_Ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      p_Ready[i] = load && (candIdx == SELW'(i));
    end
  end

  // Next-state logic for the full flag, output word, grant and arbitration pointer.
  always_comb begin
    stateD = stateQ;
    outD   = outQ;
    grantD = grantQ;
    lastD  = lastQ;
    if (load) begin
      stateD = FULL;
      outD   = candData;
      grantD = candIdx;
      lastD  = candIdx;
    end else if (stateQ == FULL && p_Out_Ready) begin
      stateD = EMPTY;
    end
  end

  // State registers; reset discards any held word and gives channel 0 first priority.
  always_ff @(posedge p_Clock) begin
    if (!p_Resetn) begin
      stateQ <= EMPTY;
      outQ   <= '0;
      grantQ <= '0;
      lastQ  <= SELW'(CHANNELS - 1);
    end else begin
      stateQ <= stateD;
      outQ   <= outD;
      grantQ <= grantD;
      lastQ  <= lastD;
    end
  end

  assign p_Output    = outQ;
  assign p_Out_Valid = (stateQ == FULL);
  assign p_Grant     = grantQ;

endmodule

// File: tb/tb_multiplexador_arbitrado.sv
// Testbench for multiplexador_arbitrado: directed vectors drive the sources,
// expected deliveries are queued as they are issued, and a monitor compares
// each word the sink accepts against the head of that queue.
module tb_multiplexador_arbitrado;

  logic        clk;
  logic        resetn;
  logic [63:0] pData;
  logic [3:0]  pValid;
  logic [3:0]  pReady;
  logic        pMode;
  logic [1:0]  pControl;
  logic [15:0] pOutput;
  logic        pOutValid;
  logic        pOutReady;
  logic [1:0]  pGrant;

  logic [15:0] dataWord [4];

  typedef struct packed {
    logic [1:0]  grant;
    logic [15:0] data;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int errors = 0;

  assign pData = {dataWord[3], dataWord[2], dataWord[1], dataWord[0]};

  multiplexador_arbitrado #(
    .WIDTH(16),
    .CHANNELS(4),
    .SELW(2)
  ) dut (
    .p_Clock(clk),
    .p_Resetn(resetn),
    .p_Data(pData),
    .p_Valid(pValid),
    .p_Ready(pReady),
    .p_Mode(pMode),
    .p_Control(pControl),
    .p_Output(pOutput),
    .p_Out_Valid(pOutValid),
    .p_Out_Ready(pOutReady),
    .p_Grant(pGrant)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic mode, input logic [1:0] control,
                               input logic [3:0] valid, input logic outReady);
    pMode     = mode;
    pControl  = control;
    pValid    = valid;
    pOutReady = outReady;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpected(input logic [1:0] grant, input logic [15:0] data);
    exp_t e;
    e.grant = grant;
    e.data  = data;
    expQ.push_back(e);
  endtask

  // Monitor: every word the sink accepts must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && pOutValid && pOutReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_delivery: got grant %0d data %0h expected no word",
                   pGrant, pOutput);
        end else begin
          e = expQ.pop_front();
          checkOutput("delivery_data", 32'(pOutput), 32'(e.data));
          checkOutput("delivery_grant", 32'(pGrant), 32'(e.grant));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 4; i++) dataWord[i] = '0;
    resetn = 1'b0;
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);

    // Reset state
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(pOutValid), 32'd0);
    checkOutput("reset_output", 32'(pOutput), 32'd0);
    checkOutput("reset_grant", 32'(pGrant), 32'd0);
    checkOutput("reset_ready", 32'(pReady), 32'd0);
    nextCycle();

    // Test 1: fixed select of channel 2
    resetn = 1'b1;
    dataWord[2] = 16'hBEEF;
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1);
    pushExpected(2'd2, 16'hBEEF);
    @(negedge clk);
    checkOutput("t1_ready", 32'(pReady), 32'b0100);
    nextCycle();
    applyStimulus(1'b0, 2'd2, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t1_out_valid", 32'(pOutValid), 32'd1);
    checkOutput("t1_output", 32'(pOutput), 32'hBEEF);
    checkOutput("t1_grant", 32'(pGrant), 32'd2);
    nextCycle();

    // Test 2: fixed select of a channel that is not valid
    applyStimulus(1'b0, 2'd1, 4'b1101, 1'b1);
    @(negedge clk);
    checkOutput("t2_ready", 32'(pReady), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_out_valid", 32'(pOutValid), 32'd0);

    // Re-reset so round-robin starts from channel 0
    nextCycle();
    resetn = 1'b0;
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    nextCycle();
    resetn = 1'b1;

    // Test 3: round-robin fairness, one word per cycle
    for (int i = 0; i < 4; i++) dataWord[i] = 16'hA000 + 16'(i);
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        pushExpected(2'(k % 4), 16'hA000 + 16'(k % 4));
      end else begin
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
      end
      @(negedge clk);
      if (k < 8) checkOutput("t3_ready", 32'(pReady), 32'(1 << (k % 4)));
      if (k >= 1) checkOutput("t3_no_bubble", 32'(pOutValid), 32'd1);
      nextCycle();
    end

    // Test 4: sink stall holds the word; release loads channel 3 on that edge
    dataWord[0] = 16'h1234;
    applyStimulus(1'b0, 2'd0, 4'b0001, 1'b0);
    pushExpected(2'd0, 16'h1234);
    @(negedge clk);
    nextCycle();
    dataWord[3] = 16'h5678;
    applyStimulus(1'b0, 2'd3, 4'b1000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("t4_hold_output", 32'(pOutput), 32'h1234);
      checkOutput("t4_hold_valid", 32'(pOutValid), 32'd1);
      checkOutput("t4_stall_ready", 32'(pReady), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 2'd3, 4'b1000, 1'b1);
    pushExpected(2'd3, 16'h5678);
    @(negedge clk);
    checkOutput("t4_release_ready", 32'(pReady), 32'b1000);
    nextCycle();
    applyStimulus(1'b0, 2'd3, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t4_output", 32'(pOutput), 32'h5678);
    checkOutput("t4_grant", 32'(pGrant), 32'd3);
    nextCycle();

    // Test 5: round-robin wraps past channels 2 and 3 after a grant to 1
    dataWord[1] = 16'h1111;
    dataWord[0] = 16'h0F0F;
    applyStimulus(1'b0, 2'd1, 4'b0010, 1'b1);
    pushExpected(2'd1, 16'h1111);
    @(negedge clk);
    nextCycle();
    applyStimulus(1'b1, 2'd0, 4'b0011, 1'b1);
    pushExpected(2'd0, 16'h0F0F);
    @(negedge clk);
    checkOutput("t5_ready", 32'(pReady), 32'b0001);
    nextCycle();
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t5_grant", 32'(pGrant), 32'd0);
    checkOutput("t5_output", 32'(pOutput), 32'h0F0F);
    nextCycle();

    // Test 6: reset discards a held word and blocks all sources
    dataWord[2] = 16'hDEAD;
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b0);
    @(negedge clk);
    nextCycle();
    applyStimulus(1'b0, 2'd2, 4'b0000, 1'b0);
    @(negedge clk);
    checkOutput("t6_held_valid", 32'(pOutValid), 32'd1);
    nextCycle();
    resetn = 1'b0;
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("t6_ready_in_reset", 32'(pReady), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("t6_out_valid", 32'(pOutValid), 32'd0);
    checkOutput("t6_output", 32'(pOutput), 32'd0);
    checkOutput("t6_grant", 32'(pGrant), 32'd0);
    checkOutput("t6_ready_held_reset", 32'(pReady), 32'd0);
    nextCycle();
    resetn = 1'b1;
    dataWord[0] = 16'h0C0C;
    pushExpected(2'd0, 16'h0C0C);
    @(negedge clk);
    checkOutput("t6_first_rr_ready", 32'(pReady), 32'b0001);
    nextCycle();
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t6_first_rr_grant", 32'(pGrant), 32'd0);
    nextCycle();
    nextCycle();

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
